// File: rtl/qbus_irq_ctrl.sv
// ---------------------------------------------------------------------------
// qbus_irq_ctrl
// Vectored-interrupt controller and INIT stretcher for the 1801VM1 system bus.
// It arbitrates NCH level-sensitive interrupt sources by programmable priority
// against the CPU PSW priority. It raises VIRQ and answers the IAKO vector read
// with the winning channel's vector and RPLY. It also generates a retriggerable
// INIT pulse of INIT_LEN cycles, and keeps the controller quiet while that
// pulse is active.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   ce        clock enable; every register advances only when ce=1
//   irq_req   level interrupt requests, bit i = channel i
//   irq_en    per-channel enable
//   irq_pri   channel i priority in [3i+2:3i]
//   irq_vec   channel i vector in [16i+15:16i]
//   psw_pri   CPU priority level (PSW[7:5])
//   iako_i    CPU interrupt-acknowledge / vector-read strobe
//   init_req  start or restart the INIT pulse
//   virq_o    vectored interrupt request to the CPU
//   rply_o    reply for the IAKO vector read
//   vec_o     vector data while rply_o=1, otherwise 0
//   irq_ack   one ce-cycle acknowledge pulse to the serviced channel
//   init_o    peripheral INIT
//   cur_ch    latched winning channel (debug)
//
// CH_W must equal clog2(NCH), with a minimum of 1.
// ---------------------------------------------------------------------------
module qbus_irq_ctrl #(
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int INIT_LEN = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [NCH-1:0]    irq_req,
  input  logic [NCH-1:0]    irq_en,
  input  logic [3*NCH-1:0]  irq_pri,
  input  logic [16*NCH-1:0] irq_vec,
  input  logic [2:0]        psw_pri,
  input  logic              iako_i,
  input  logic              init_req,
  output logic              virq_o,
  output logic              rply_o,
  output logic [15:0]       vec_o,
  output logic [NCH-1:0]    irq_ack,
  output logic              init_o,
  output logic [CH_W-1:0]   cur_ch
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  // ---- stage p0: combinational eligibility and arbitration ----
  logic [2:0]      pri_a [NCH];
  logic [15:0]     vec_a [NCH];
  logic [NCH-1:0]  elig_p0;
  logic            any_elig_p0;
  logic [CH_W-1:0] win_idx_p0;
  logic [2:0]      win_pri_p0;
  logic            quiet_p0;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign pri_a[g]   = irq_pri[3*g +: 3];
    assign vec_a[g]   = irq_vec[16*g +: 16];
    // pri 0 can never beat any psw_pri, and psw_pri 7 masks every channel.
    assign elig_p0[g] = irq_req[g] & irq_en[g] & (pri_a[g] > psw_pri);
  end

  // Scanning upward and replacing only on a strictly higher priority makes
  // ties resolve to the lowest index.
  always_comb begin
    any_elig_p0 = 1'b0;
    win_idx_p0  = '0;
    win_pri_p0  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (elig_p0[i] && (!any_elig_p0 || (pri_a[i] > win_pri_p0))) begin
        any_elig_p0 = 1'b1;
        win_idx_p0  = CH_W'(i);
        win_pri_p0  = pri_a[i];
      end
    end
  end

  // While INIT is active (or being requested) the controller stays silent.
  assign quiet_p0 = init_o | init_req;

  // ---- stage p1: registered state and outputs ----
  state_t          state_p1, state_n;
  logic [15:0]     lvec_p1, lvec_n;
  logic [7:0]      init_cnt_p1, init_cnt_n;
  logic            virq_n, rply_n;
  logic [15:0]     vec_n;
  logic [NCH-1:0]  ack_n;
  logic [CH_W-1:0] cur_n;

  always_comb begin
    if (init_req)
      init_cnt_n = 8'(INIT_LEN);
    else if (init_cnt_p1 != 8'd0)
      init_cnt_n = init_cnt_p1 - 8'd1;
    else
      init_cnt_n = 8'd0;
  end

  always_comb begin
    state_n = state_p1;
    virq_n  = virq_o;
    rply_n  = rply_o;
    vec_n   = vec_o;
    ack_n   = '0;
    cur_n   = cur_ch;
    lvec_n  = lvec_p1;
    if (quiet_p0) begin
      // cur_ch deliberately keeps its value across INIT.
      state_n = IDLE;
      virq_n  = 1'b0;
      rply_n  = 1'b0;
      vec_n   = '0;
    end else begin
      unique case (state_p1)
        IDLE: begin
          // A spurious iako_i here gets no reply; the CPU bus timeout
          // deals with it.
          virq_n = 1'b0;
          rply_n = 1'b0;
          vec_n  = '0;
          if (any_elig_p0) begin
            cur_n   = win_idx_p0;
            lvec_n  = vec_a[win_idx_p0];
            virq_n  = 1'b1;
            state_n = PEND;
          end
        end
        PEND: begin
          if (iako_i) begin
            rply_n        = 1'b1;
            vec_n         = lvec_p1;
            ack_n[cur_ch] = 1'b1;
            virq_n        = 1'b0;
            state_n       = ACK;
          end else if (!elig_p0[cur_ch]) begin
            // Withdrawn; IDLE re-arbitrates on the following cycle.
            virq_n  = 1'b0;
            state_n = IDLE;
          end else if (any_elig_p0 && (win_pri_p0 > pri_a[cur_ch])) begin
            cur_n  = win_idx_p0;
            lvec_n = vec_a[win_idx_p0];
          end
        end
        ACK: begin
          if (!iako_i) begin
            rply_n  = 1'b0;
            vec_n   = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1    <= IDLE;
      virq_o      <= 1'b0;
      rply_o      <= 1'b0;
      vec_o       <= '0;
      irq_ack     <= '0;
      cur_ch      <= '0;
      init_cnt_p1 <= 8'd0;
      init_o      <= 1'b0;
    end else if (ce) begin
      state_p1    <= state_n;
      virq_o      <= virq_n;
      rply_o      <= rply_n;
      vec_o       <= vec_n;
      // Holding through ce=0 stretches the pulse to exactly one ce cycle.
      irq_ack     <= ack_n;
      cur_ch      <= cur_n;
      init_cnt_p1 <= init_cnt_n;
      init_o      <= (init_cnt_n != 8'd0);
    end
  end

  // The latched vector is only observed after being loaded in IDLE/PEND,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (ce) lvec_p1 <= lvec_n;
  end

endmodule

// File: tb/tb_qbus_irq_ctrl.sv
module tb_qbus_irq_ctrl;
  localparam int NCH = 4;
  localparam int CH_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ce = 1'b1;
  logic [NCH-1:0]    irq_req = '0;
  logic [NCH-1:0]    irq_en = '0;
  logic [3*NCH-1:0]  irq_pri = '0;
  logic [16*NCH-1:0] irq_vec = '0;
  logic [2:0]        psw_pri = '0;
  logic              iako_i = 1'b0;
  logic              init_req = 1'b0;
  logic              virq_o, rply_o, init_o;
  logic [15:0]       vec_o;
  logic [NCH-1:0]    irq_ack;
  logic [CH_W-1:0]   cur_ch;

  int passed = 0;
  int total  = 0;

  qbus_irq_ctrl #(.NCH(NCH), .CH_W(CH_W), .INIT_LEN(10)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .irq_req(irq_req), .irq_en(irq_en), .irq_pri(irq_pri), .irq_vec(irq_vec),
    .psw_pri(psw_pri), .iako_i(iako_i), .init_req(init_req),
    .virq_o(virq_o), .rply_o(rply_o), .vec_o(vec_o), .irq_ack(irq_ack),
    .init_o(init_o), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic setch(input int ch, input logic [2:0] p, input logic [15:0] v);
    irq_pri[3*ch +: 3]  = p;
    irq_vec[16*ch +: 16] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    irq_en = 4'b1111;
    #2 reset = 1'b1;
    step(); step();
    chk("rst_virq", virq_o, 0);
    chk("rst_rply", rply_o, 0);
    chk("rst_vec", vec_o, 0);
    chk("rst_ack", irq_ack, 0);
    chk("rst_init", init_o, 0);
    chk("rst_cur", cur_ch, 0);
    reset = 1'b0;
    step();

    // Equal-priority tie: ch1 wins, then ch2.
    setch(1, 3'd4, 16'o060);
    setch(2, 3'd4, 16'o064);
    irq_req = 4'b0110;
    step();
    chk("t1_virq", virq_o, 1);
    chk("t1_cur", cur_ch, 1);
    iako_i = 1'b1;
    step();
    chk("t1_rply", rply_o, 1);
    chk("t1_vec", vec_o, 16'o060);
    chk("t1_ack", irq_ack, 4'b0010);
    chk("t1_virq_clr", virq_o, 0);
    step();
    chk("t1_ack_once", irq_ack, 0);
    chk("t1_rply_hold", rply_o, 1);
    chk("t1_vec_hold", vec_o, 16'o060);
    iako_i = 1'b0;
    irq_req = 4'b0100;
    step();
    chk("t1_rply_rel", rply_o, 0);
    chk("t1_vec_rel", vec_o, 0);
    step();
    chk("t1_virq2", virq_o, 1);
    chk("t1_cur2", cur_ch, 2);
    iako_i = 1'b1;
    step();
    chk("t1_vec2", vec_o, 16'o064);
    chk("t1_ack2", irq_ack, 4'b0100);
    iako_i = 1'b0;
    irq_req = 4'b0000;
    step();
    step();
    chk("t1_idle", virq_o, 0);

    // Pre-emption in PEND by a higher-priority channel.
    setch(0, 3'd3, 16'o100);
    setch(3, 3'd6, 16'o300);
    irq_req = 4'b0001;
    step();
    chk("t2_cur0", cur_ch, 0);
    irq_req = 4'b1001;
    step();
    chk("t2_cur3", cur_ch, 3);
    chk("t2_virq", virq_o, 1);
    iako_i = 1'b1;
    step();
    chk("t2_vec3", vec_o, 16'o300);
    chk("t2_ack3", irq_ack, 4'b1000);
    iako_i = 1'b0;
    irq_req = 4'b0001;
    step();
    step();
    chk("t2_cur0b", cur_ch, 0);
    iako_i = 1'b1;
    step();
    chk("t2_vec0", vec_o, 16'o100);
    chk("t2_ack0", irq_ack, 4'b0001);
    iako_i = 1'b0;
    irq_req = 4'b0000;
    step();
    step();

    // Withdrawal by raising psw_pri to the channel priority.
    setch(0, 3'd5, 16'o200);
    irq_req = 4'b0001;
    step();
    chk("t3_virq", virq_o, 1);
    psw_pri = 3'd5;
    step();
    chk("t3_virq_drop", virq_o, 0);
    chk("t3_no_ack", irq_ack, 0);
    step();
    chk("t3_masked", virq_o, 0);
    psw_pri = 3'd0;
    step();
    chk("t3_virq_re", virq_o, 1);
    irq_req = 4'b0000;
    step();
    step();

    // Single INIT pulse: high exactly 10 cycles.
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    chk("t4_init_1", init_o, 1);
    for (int k = 2; k <= 10; k++) begin
      step();
      chk("t4_init_hi", init_o, 1);
    end
    step();
    chk("t4_init_lo", init_o, 0);

    // Retrigger at cycle 6 with an interrupt pending throughout.
    init_req = 1'b1;
    irq_req = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      step();
      init_req = (k == 5);
      chk("t4_rt_init", init_o, (k <= 15) ? 1 : 0);
      chk("t4_rt_virq", virq_o, 0);
    end
    step();
    chk("t4_virq_after", virq_o, 1);
    irq_req = 4'b0000;
    step();
    step();

    // Clock-enable stretched handshake on ch1.
    irq_req = 4'b0010;
    ce = 1'b0;
    step();
    chk("t5_frozen", virq_o, 0);
    ce = 1'b1;
    step();
    chk("t5_virq", virq_o, 1);
    iako_i = 1'b1;
    ce = 1'b0;
    step();
    chk("t5_rply_wait", rply_o, 0);
    ce = 1'b1;
    step();
    chk("t5_rply", rply_o, 1);
    chk("t5_ack", irq_ack, 4'b0010);
    ce = 1'b0;
    step();
    chk("t5_ack_held", irq_ack, 4'b0010);
    ce = 1'b1;
    step();
    chk("t5_ack_gone", irq_ack, 0);
    chk("t5_rply_hold", rply_o, 1);
    iako_i = 1'b0;
    irq_req = 4'b0000;
    ce = 1'b0;
    step();
    chk("t5_rply_frz", rply_o, 1);
    ce = 1'b1;
    step();
    chk("t5_rply_rel", rply_o, 0);
    step();

    // Asynchronous reset in the middle of ACK.
    irq_req = 4'b0010;
    step();
    iako_i = 1'b1;
    step();
    chk("t6_in_ack", rply_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rply", rply_o, 0);
    chk("t6_vec", vec_o, 0);
    chk("t6_virq", virq_o, 0);
    chk("t6_init", init_o, 0);
    chk("t6_cur", cur_ch, 0);
    iako_i = 1'b0;
    psw_pri = 3'd7;
    irq_req = 4'b1111;
    step();
    reset = 1'b0;
    step();
    step();
    chk("t6_psw7", virq_o, 0);
    chk("t6_noinit", init_o, 0);
    psw_pri = 3'd5;
    step();
    chk("t6_psw5_virq", virq_o, 1);
    chk("t6_psw5_cur", cur_ch, 3);
    irq_req = 4'b0000;
    step();
    step();

    // Priority 0 is never eligible, even with psw_pri 0.
    psw_pri = 3'd0;
    setch(0, 3'd0, 16'o200);
    irq_req = 4'b0001;
    step();
    step();
    chk("t7_pri0", virq_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
